// File: rtl/uart_tx_fifo_if.sv
// Byte-producer handshake into the UART transmitter FIFO.
// The producer drives valid/data; the transmitter answers with ready.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic                 in_valid;
    logic [DATA_BITS-1:0] in_data;
    logic                 in_ready;

    modport master (output in_valid, output in_data, input  in_ready);
    modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and built-in baud timing.
// Frames stream back to back while enabled and the FIFO has data.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    uart_tx_fifo_if.slave                 in_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          tx
);
    localparam int DIV = CLK_FREQ / BAUD_RATE;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int TW  = $clog2(STOP_BITS * DIV);
    localparam int IW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               state_q, state_d;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]          level_q, level_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rd_data;
    logic                 wr_en, pop, can_pop, bit_end, stop_end;

    assign in_if.in_ready = (level_q != (AW+1)'(FIFO_DEPTH));
    assign wr_en          = in_if.in_valid & in_if.in_ready;
    assign can_pop        = en && (level_q != '0);
    assign rd_data        = mem_q[rd_ptr_q];
    assign bit_end        = (cnt_q == TW'(DIV - 1));
    assign stop_end       = (cnt_q == TW'(STOP_BITS * DIV - 1));
    assign fifo_level     = level_q;
    assign busy           = busy_q;
    assign tx             = tx_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_if.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + TW'(1);
        idx_d   = idx_q;
        sh_d    = sh_q;
        par_d   = par_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (can_pop) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    if (idx_q == IW'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    else
                        idx_d = idx_q + IW'(1);
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Chaining straight into START keeps bursts free of idle gaps.
                if (stop_end) begin
                    cnt_d = '0;
                    if (can_pop) begin
                        pop     = 1'b1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (pop) begin
            sh_d  = rd_data;
            par_d = ^rd_data;
        end

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (wr_en && !pop)      level_d = level_q + (AW+1)'(1);
        else if (!wr_en && pop) level_d = level_q - (AW+1)'(1);

        // tx is one register behind the state, so it falls the edge after the pop.
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_q[0];
            S_PARITY: tx_d = (PARITY == 2) ? ~par_q : par_q;
            default:  tx_d = 1'b1;
        endcase

        busy_d = (state_d != S_IDLE) || (level_q != '0);
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 8E1, 7O2) at DIV=217,
// with a per-instance scoreboard of written bytes checked against decoded frames.
module tb_uart_tx_fifo;
    localparam int DIV = 217;

    logic clk = 1'b0;
    logic rst_n;
    logic en0, en1, en2;
    logic tx0, tx1, tx2, busy0, busy1, busy2;
    logic [4:0] lvl0, lvl1, lvl2;

    int errors = 0;
    int nchk   = 0;
    int cyc    = 0;
    int rise [3];
    int fall [3];
    logic [2:0] bsy;
    logic [2:0] pbsy = '0;

    logic [8:0] q0 [$];
    logic [8:0] q1 [$];
    logic [8:0] q2 [$];

    uart_tx_fifo_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_if #(.DATA_BITS(7)) if2 ();

    uart_tx_fifo dut0 (.clk(clk), .rst_n(rst_n), .en(en0), .in_if(if0),
                       .fifo_level(lvl0), .busy(busy0), .tx(tx0));
    uart_tx_fifo #(.PARITY(1)) dut1 (.clk(clk), .rst_n(rst_n), .en(en1), .in_if(if1),
                       .fifo_level(lvl1), .busy(busy1), .tx(tx1));
    uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) dut2 (.clk(clk), .rst_n(rst_n),
                       .en(en2), .in_if(if2), .fifo_level(lvl2), .busy(busy2), .tx(tx2));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bsy = {busy2, busy1, busy0};
    always @(negedge clk) begin
        pbsy <= bsy;
        for (int i = 0; i < 3; i++) begin
            if (bsy[i] === 1'b1 && pbsy[i] === 1'b0) rise[i] <= cyc;
            if (bsy[i] === 1'b0 && pbsy[i] === 1'b1) fall[i] <= cyc;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic txv(input int w);
        case (w)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic logic rdyv(input int w);
        case (w)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic qpop(input int w, output logic [8:0] d, output int had);
        d = '0;
        case (w)
            0:       begin had = q0.size(); if (had > 0) d = q0.pop_front(); end
            1:       begin had = q1.size(); if (had > 0) d = q1.pop_front(); end
            default: begin had = q2.size(); if (had > 0) d = q2.pop_front(); end
        endcase
    endtask

    task automatic set_en(input int w, input logic v);
        case (w)
            0:       en0 = v;
            1:       en1 = v;
            default: en2 = v;
        endcase
    endtask

    // Drive one beat for a cycle; push to the scoreboard only if the bench expects acceptance.
    task automatic wr(input int w, input logic [8:0] d, input bit exp_acc, input string tag);
        case (w)
            0:       begin if0.in_valid = 1'b1; if0.in_data = d[7:0]; end
            1:       begin if1.in_valid = 1'b1; if1.in_data = d[7:0]; end
            default: begin if2.in_valid = 1'b1; if2.in_data = d[6:0]; end
        endcase
        chk({tag, "/rdy"}, rdyv(w), exp_acc);
        if (exp_acc) begin
            case (w)
                0:       q0.push_back(d);
                1:       q1.push_back(d);
                default: q2.push_back(d);
            endcase
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
        if1.in_valid = 1'b0;
        if2.in_valid = 1'b0;
    endtask

    task automatic wait_low(input int w, input string tag);
        int n = 0;
        while (txv(w) !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "/start"}, txv(w), 0);
    endtask

    task automatic hold_high(input int w, input int n, input string tag);
        int lows = 0;
        repeat (n) begin
            @(negedge clk);
            if (txv(w) !== 1'b1) lows++;
        end
        chk({tag, "/lows"}, lows, 0);
    endtask

    // Samples every frame bit at its first and last clock; returns on the first clock after the frame.
    task automatic rx_check(input int w, input int db, input int pm, input int sb,
                            input bit b2b, input int drop_at, input string tag);
        logic [15:0] ef, se, sl;
        logic [8:0]  d;
        logic        par;
        int          nb, had, pb;
        pb = (pm != 0) ? 1 : 0;
        nb = 1 + db + pb + sb;
        wait_low(w, tag);
        qpop(w, d, had);
        chk({tag, "/sbq"}, (had > 0), 1);
        par = 1'b0;
        for (int i = 0; i < db; i++) par ^= d[i];
        if (pm == 2) par = ~par;
        ef = '0;
        se = '0;
        sl = '0;
        for (int i = 0; i < db; i++) ef[1+i] = d[i];
        if (pm != 0) ef[1+db] = par;
        for (int i = 0; i < sb; i++) ef[1+db+pb+i] = 1'b1;
        for (int p = 0; p < nb; p++) begin
            if (p == drop_at) set_en(w, 1'b0);
            se[p] = txv(w);
            repeat (DIV - 1) @(negedge clk);
            sl[p] = txv(w);
            @(negedge clk);
        end
        chk({tag, "/early"}, se, ef);
        chk({tag, "/late"}, sl, ef);
        if (b2b) chk({tag, "/b2b"}, txv(w), 0);
    endtask

    initial begin
        logic [8:0] junk;
        int had;
        rst_n = 1'b0;
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        if0.in_valid = 1'b0; if0.in_data = '0;
        if1.in_valid = 1'b0; if1.in_data = '0;
        if2.in_valid = 1'b0; if2.in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst/tx", tx0, 1);
        chk("rst/busy", busy0, 0);
        chk("rst/lvl", lvl0, 0);
        chk("rst/rdy", if0.in_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 single byte: latency, frame content, busy duration
        wr(0, 9'h0A5, 1, "t1");
        chk("t1/k_busy", busy0, 0);
        chk("t1/k_lvl", lvl0, 1);
        chk("t1/k_tx", tx0, 1);
        @(negedge clk);
        chk("t1/k1_busy", busy0, 1);
        chk("t1/k1_lvl", lvl0, 0);
        chk("t1/k1_tx", tx0, 1);
        @(negedge clk);
        chk("t1/k2_tx", tx0, 0);
        rx_check(0, 8, 0, 1, 0, -1, "t1");
        chk("t1/busy_len", fall[0] - rise[0], 2170);

        // even parity, 11-bit frame
        wr(1, 9'h0A5, 1, "t2");
        rx_check(1, 8, 1, 1, 0, -1, "t2");
        chk("t2/busy_len", fall[1] - rise[1], 2387);

        // 7 data bits, odd parity, two stop bits, back to back
        wr(2, 9'h07F, 1, "t4a");
        wr(2, 9'h000, 1, "t4b");
        rx_check(2, 7, 2, 2, 1, -1, "t4a");
        rx_check(2, 7, 2, 2, 0, -1, "t4b");

        // fill to full with transmit disabled, then drain as a burst
        en0 = 1'b0;
        for (int i = 0; i < 16; i++) wr(0, 9'((i * 37 + 3) & 8'hFF), 1, "t3/wr");
        chk("t3/full_lvl", lvl0, 16);
        wr(0, 9'h0FF, 0, "t3/wr17");
        chk("t3/lvl17", lvl0, 16);
        en0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_check(0, 8, 0, 1, (i < 15), -1, "t3");
            if (i < 15) chk("t3/lvl", lvl0, 14 - i);
        end
        hold_high(0, 2500, "t3/no17");
        chk("t3/end_lvl", lvl0, 0);
        chk("t3/end_busy", busy0, 0);

        // enable gating: queued bytes wait, en drop mid-frame lets the frame finish
        en0 = 1'b0;
        wr(0, 9'h081, 1, "t5");
        wr(0, 9'h042, 1, "t5");
        wr(0, 9'h0C3, 1, "t5");
        hold_high(0, 400, "t5/hold");
        chk("t5/busy", busy0, 1);
        chk("t5/lvl", lvl0, 3);
        en0 = 1'b1;
        rx_check(0, 8, 0, 1, 1, -1, "t5a");
        rx_check(0, 8, 0, 1, 0, 4, "t5b");
        hold_high(0, 600, "t5/held");
        chk("t5/held_lvl", lvl0, 1);
        chk("t5/held_busy", busy0, 1);
        en0 = 1'b1;
        rx_check(0, 8, 0, 1, 0, -1, "t5c");

        // async reset during DATA abandons the frame
        wr(0, 9'h05A, 1, "t6");
        wait_low(0, "t6");
        repeat (DIV * 3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6/tx", tx0, 1);
        chk("t6/busy", busy0, 0);
        chk("t6/lvl", lvl0, 0);
        qpop(0, junk, had);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wr(0, 9'h03C, 1, "t6b");
        rx_check(0, 8, 0, 1, 0, -1, "t6b");

        $display("Result: errors=%0d of %0d checks", errors, nchk);
        $finish;
    end
endmodule
